// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: status-register bit positions,
// default datapath widths and the MEM-stage control bundle.
package arm_pkg;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   localparam int ARM_DATA_W = 32;
   localparam int ARM_REG_W  = 4;

   typedef struct packed {
      logic valid;
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
   } mem_ctrl_t;

endpackage

// File: rtl/status_reg.sv
// Four-bit flag register with load enable and synchronous active-low reset.
// Kept generic so it can be reused for banked saved-status registers.
module status_reg #(
   parameter logic [3:0] RST_VAL = 4'b0000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [3:0] d,
   output logic [3:0] q
);

   // Load new flags when enabled; reset takes priority.
   always_ff @(posedge clk) begin
      if (!rst)
         q <= RST_VAL;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register. Captures the ALU result, store data, destination
// and control bits, owns the NZCV status register and counts instructions that
// cross into MEM. Priority per edge: reset > flush > freeze > normal load.
module exe_mem_stage_reg
   import arm_pkg::*;
#(
   parameter int         DATA_W = ARM_DATA_W,
   parameter int         REG_W  = ARM_REG_W,
   parameter int         CNT_W  = 16,
   parameter logic [3:0] SR_RST = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              exe_valid,
   input  logic              exe_wb_en,
   input  logic              exe_mem_r_en,
   input  logic              exe_mem_w_en,
   input  logic              exe_s,
   input  logic [REG_W-1:0]  exe_dest,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [3:0]        alu_status,
   input  logic [DATA_W-1:0] val_rm,
   output logic              mem_valid,
   output logic              mem_wb_en,
   output logic              mem_mem_r_en,
   output logic              mem_mem_w_en,
   output logic [REG_W-1:0]  mem_dest,
   output logic [DATA_W-1:0] mem_alu_res,
   output logic [DATA_W-1:0] mem_val_rm,
   output logic [3:0]        sr,
   output logic              alu_carry,
   output logic              mem_is_load,
   output logic [CNT_W-1:0]  inst_cnt
);

   mem_ctrl_t ctrl_q;
   mem_ctrl_t ctrl_d;
   logic      load;
   logic      sr_ld;

   // A normal-load edge: neither flushed nor stalled.
   assign load  = !flush && !freeze;
   // Flags change only for a real instruction that asked for it (S bit).
   assign sr_ld = load && exe_valid && exe_s;

   // Control bits of a non-valid instruction are squashed so the bubble is clean.
   always_comb begin
      ctrl_d          = '0;
      ctrl_d.valid    = exe_valid;
      ctrl_d.wb_en    = exe_valid & exe_wb_en;
      ctrl_d.mem_r_en = exe_valid & exe_mem_r_en;
      ctrl_d.mem_w_en = exe_valid & exe_mem_w_en;
   end

   // Control register: flush inserts a bubble, freeze holds.
   always_ff @(posedge clk) begin
      if (!rst)
         ctrl_q <= '0;
      else if (flush)
         ctrl_q <= '0;
      else if (!freeze)
         ctrl_q <= ctrl_d;
   end

   // Data registers: load on every normal edge (even for bubbles), hold on flush/freeze.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_dest    <= '0;
         mem_alu_res <= '0;
         mem_val_rm  <= '0;
      end else if (load) begin
         mem_dest    <= exe_dest;
         mem_alu_res <= alu_res;
         mem_val_rm  <= val_rm;
      end
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk) begin
      if (!rst)
         inst_cnt <= '0;
      else if (load && exe_valid)
         inst_cnt <= inst_cnt + 1'b1;
   end

   status_reg #(
      .RST_VAL (SR_RST)
   ) u_sr (
      .clk (clk),
      .rst (rst),
      .ld  (sr_ld),
      .d   (alu_status),
      .q   (sr)
   );

   assign mem_valid    = ctrl_q.valid;
   assign mem_wb_en    = ctrl_q.wb_en;
   assign mem_mem_r_en = ctrl_q.mem_r_en;
   assign mem_mem_w_en = ctrl_q.mem_w_en;

   // Registered carry feeds the ALU, so an S instruction sees the previous carry.
   assign alu_carry   = sr[SR_C];
   assign mem_is_load = ctrl_q.valid & ctrl_q.mem_r_en;

endmodule
